// File: rtl/bridgetx.sv
// bridgetx -- transmit-side E1 -> STM-1 byte bridge.
//
// Owns the STM-1 byte-slot counter (row 0..8, col 0..89, sts 0..2; sts is
// the fastest digit) and decodes it into one enable per byte source. The
// selected source byte is captured into the registered dataout bus one
// cycle after its slot. AU4 pointer justification requests are scheduled
// onto whole frames by a small FSM.
//
// Ports
//   clk19            19.44 MHz clock, rising edge
//   rst              asynchronous active-low reset
//   row/col/sts      current slot counter
//   frmst            high in slot row=col=sts=0
//   stmen/au4en/vc4en/tug3en   per-source slot enables (combinational)
//   increq/decreq    positive / negative justification request pulses
//   ainc/adec        justification active for the current frame
//   stmdi/au4di/vc4di/tug3di   source bytes
//   dataout          registered STM-1 byte, one cycle behind its slot
module bridgetx #(
  parameter int WID  = 8,
  parameter int RWID = 4,
  parameter int CWID = 7,
  parameter int SWID = 2
) (
  input  logic            clk19,
  input  logic            rst,
  output logic [RWID-1:0] row,
  output logic [CWID-1:0] col,
  output logic [SWID-1:0] sts,
  output logic            frmst,
  output logic            stmen,
  output logic            au4en,
  output logic            vc4en,
  output logic            tug3en,
  input  logic            increq,
  input  logic            decreq,
  output logic            ainc,
  output logic            adec,
  input  logic [WID-1:0]  stmdi,
  input  logic [WID-1:0]  au4di,
  input  logic [WID-1:0]  vc4di,
  input  logic [WID-1:0]  tug3di,
  output logic [WID-1:0]  dataout
);

  localparam logic [RWID-1:0] ROW_2    = RWID'(2);
  localparam logic [RWID-1:0] ROW_3    = RWID'(3);
  localparam logic [RWID-1:0] ROW_4    = RWID'(4);
  localparam logic [RWID-1:0] ROW_LAST = RWID'(8);
  localparam logic [CWID-1:0] COL_2    = CWID'(2);
  localparam logic [CWID-1:0] COL_3    = CWID'(3);
  localparam logic [CWID-1:0] COL_5    = CWID'(5);
  localparam logic [CWID-1:0] COL_6    = CWID'(6);
  localparam logic [CWID-1:0] COL_LAST = CWID'(89);
  localparam logic [SWID-1:0] STS_LAST = SWID'(2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_JUST  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  logic [RWID-1:0] row_q, row_d;
  logic [CWID-1:0] col_q, col_d;
  logic [SWID-1:0] sts_q, sts_d;
  state_t          state_q, state_d;
  logic            neg_q, neg_d;        // pending request type: 1 = negative
  logic [1:0]      holdoff_q, holdoff_d;
  logic            ainc_q, ainc_d;
  logic            adec_q, adec_d;
  logic [WID-1:0]  dataout_q, dataout_d;

  logic            is_row3_s;
  logic            pos_stuff_s;
  logic            neg_h3_s;

  // Slot counter next state: sts fastest, then col, then row.
  always_comb begin
    sts_d = sts_q;
    col_d = col_q;
    row_d = row_q;
    if (sts_q == STS_LAST) begin
      sts_d = '0;
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d = '0;
        end else begin
          row_d = row_q + RWID'(1);
        end
      end else begin
        col_d = col_q + CWID'(1);
      end
    end else begin
      sts_d = sts_q + SWID'(1);
    end
  end

  assign frmst = (row_q == '0) && (col_q == '0) && (sts_q == '0);

  // Justification only reshapes row 3: positive stuffs col 3, negative
  // hands the H3 column (col 2) over to VC4 data.
  assign is_row3_s   = (row_q == ROW_3);
  assign pos_stuff_s = ainc_q && is_row3_s && (col_q == COL_3);
  assign neg_h3_s    = adec_q && is_row3_s && (col_q == COL_2);

  assign stmen  = ((row_q <= ROW_2) || (row_q >= ROW_4)) && (col_q <= COL_2);
  assign au4en  = is_row3_s && (col_q <= COL_2) && !neg_h3_s;
  assign vc4en  = ((col_q >= COL_3) && (col_q <= COL_5) && !pos_stuff_s) || neg_h3_s;
  assign tug3en = (col_q >= COL_6) && (sts_q == '0);

  // Byte mux; slots with no enable (spare sts and stuff bytes) carry zero.
  always_comb begin
    dataout_d = '0;
    if (stmen) begin
      dataout_d = stmdi;
    end else if (au4en) begin
      dataout_d = au4di;
    end else if (vc4en) begin
      dataout_d = vc4di;
    end else if (tug3en) begin
      dataout_d = tug3di;
    end else begin
      dataout_d = '0;
    end
  end

  // Justification FSM: a request is armed, applied to the whole next frame,
  // then followed by three frame starts of holdoff before re-arming.
  always_comb begin
    state_d   = state_q;
    neg_d     = neg_q;
    holdoff_d = holdoff_q;
    ainc_d    = ainc_q;
    adec_d    = adec_q;
    case (state_q)
      ST_IDLE: begin
        if (increq ^ decreq) begin
          state_d = ST_ARMED;
          neg_d   = decreq;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (frmst) begin
          state_d = ST_JUST;
          ainc_d  = !neg_q;
          adec_d  = neg_q;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_JUST: begin
        if (frmst) begin
          state_d   = ST_HOLD;
          ainc_d    = 1'b0;
          adec_d    = 1'b0;
          holdoff_d = 2'd3;
        end else begin
          state_d = ST_JUST;
        end
      end
      ST_HOLD: begin
        if (frmst) begin
          holdoff_d = holdoff_q - 2'd1;
          if (holdoff_q == 2'd1) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        neg_d     = 1'b0;
        holdoff_d = 2'd0;
        ainc_d    = 1'b0;
        adec_d    = 1'b0;
      end
    endcase
  end

  // All state registers, cleared asynchronously.
  always_ff @(posedge clk19 or negedge rst) begin
    if (!rst) begin
      row_q     <= '0;
      col_q     <= '0;
      sts_q     <= '0;
      state_q   <= ST_IDLE;
      neg_q     <= 1'b0;
      holdoff_q <= 2'd0;
      ainc_q    <= 1'b0;
      adec_q    <= 1'b0;
      dataout_q <= '0;
    end else begin
      row_q     <= row_d;
      col_q     <= col_d;
      sts_q     <= sts_d;
      state_q   <= state_d;
      neg_q     <= neg_d;
      holdoff_q <= holdoff_d;
      ainc_q    <= ainc_d;
      adec_q    <= adec_d;
      dataout_q <= dataout_d;
    end
  end

  assign row     = row_q;
  assign col     = col_q;
  assign sts     = sts_q;
  assign ainc    = ainc_q;
  assign adec    = adec_q;
  assign dataout = dataout_q;

endmodule

// File: tb/tb_bridgetx.sv
// Testbench for bridgetx: random source bytes and request pulses, checked
// every cycle against a frame-arithmetic model of slot position and
// justification scheduling, plus literal expectations pinning the model.
module tb_bridgetx;

  localparam int FRM = 2430;

  logic       clk19 = 1'b0;
  logic       rst   = 1'b0;
  logic [3:0] row;
  logic [6:0] col;
  logic [1:0] sts;
  logic       frmst, stmen, au4en, vc4en, tug3en;
  logic       increq = 1'b0, decreq = 1'b0;
  logic       ainc, adec;
  logic [7:0] stmdi = 8'h00, au4di = 8'h00, vc4di = 8'h00, tug3di = 8'h00;
  logic [7:0] dataout;

  bridgetx dut (
    .clk19(clk19), .rst(rst), .row(row), .col(col), .sts(sts),
    .frmst(frmst), .stmen(stmen), .au4en(au4en), .vc4en(vc4en),
    .tug3en(tug3en), .increq(increq), .decreq(decreq),
    .ainc(ainc), .adec(adec), .stmdi(stmdi), .au4di(au4di),
    .vc4di(vc4di), .tug3di(tug3di), .dataout(dataout)
  );

  always #5 clk19 = ~clk19;

  int n_cmp = 0;
  int n_bad = 0;
  int t = 0;        // cycles since reset release
  int run = 0;
  bit chk_en = 1'b0;

  // model state: frame number carrying a justification and its type
  int jframe = -10;
  bit jneg = 1'b0;
  logic [7:0] prev_slot = 8'h00;

  int exp_row, exp_col, exp_sts;
  bit exp_frm, exp_stm, exp_au4, exp_vc4, exp_tug, exp_ainc, exp_adec;
  logic [7:0] exp_dout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s run=%0d t=%0d got=%0h want=%0h", name, run, t, act, expv);
    end
  endtask

  // One bench cycle: drive inputs, compute what the outputs must be, advance.
  task automatic step(input bit inc, input bit dec, input bit fixed);
    int pos, f, r, c, s;
    bit jnow, ep, en;
    logic [7:0] slot;
    increq = inc;
    decreq = dec;
    if (fixed) begin
      stmdi = 8'h11; au4di = 8'h22; vc4di = 8'h33; tug3di = 8'h44;
    end else begin
      stmdi = 8'($urandom); au4di = 8'($urandom);
      vc4di = 8'($urandom); tug3di = 8'($urandom);
    end
    pos = t % FRM; f = t / FRM;
    r = pos / 270; c = (pos % 270) / 3; s = pos % 3;
    exp_row = r; exp_col = c; exp_sts = s;
    exp_frm = (pos == 0);
    jnow = (f == jframe);
    ep = jnow && !jneg && r == 3 && c == 3;
    en = jnow &&  jneg && r == 3 && c == 2;
    exp_stm = (r <= 2 || r >= 4) && c <= 2;
    exp_au4 = r == 3 && c <= 2 && !en;
    exp_vc4 = (c >= 3 && c <= 5 && !ep) || en;
    exp_tug = c >= 6 && s == 0;
    exp_ainc = !jneg && t >= jframe * FRM + 1 && t <= jframe * FRM + FRM;
    exp_adec =  jneg && t >= jframe * FRM + 1 && t <= jframe * FRM + FRM;
    exp_dout = (t == 0) ? 8'h00 : prev_slot;
    if (exp_stm) slot = stmdi;
    else if (exp_au4) slot = au4di;
    else if (exp_vc4) slot = vc4di;
    else if (exp_tug) slot = tug3di;
    else slot = 8'h00;
    prev_slot = slot;
    // accepted only once the previous justification's holdoff has expired
    if ((inc ^ dec) && t >= (jframe + 4) * FRM + 1) begin
      jframe = f + 1;
      jneg = dec;
    end
    chk_en = 1'b1;
    @(posedge clk19);
    #1;
    t++;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst = 1'b0;
    increq = 1'b0;
    decreq = 1'b0;
    repeat (3) @(posedge clk19);
    #1;
    rst = 1'b1;
    t = 0;
    jframe = -10;
    jneg = 1'b0;
  endtask

  // Compare process: every output, every cycle, plus pinned literals.
  always @(negedge clk19) begin
    if (chk_en) begin
      chk("row", 32'(row), 32'(exp_row));
      chk("col", 32'(col), 32'(exp_col));
      chk("sts", 32'(sts), 32'(exp_sts));
      chk("frmst", 32'(frmst), 32'(exp_frm));
      chk("stmen", 32'(stmen), 32'(exp_stm));
      chk("au4en", 32'(au4en), 32'(exp_au4));
      chk("vc4en", 32'(vc4en), 32'(exp_vc4));
      chk("tug3en", 32'(tug3en), 32'(exp_tug));
      chk("ainc", 32'(ainc), 32'(exp_ainc));
      chk("adec", 32'(adec), 32'(exp_adec));
      chk("dataout", 32'(dataout), 32'(exp_dout));
      if (run == 0) begin
        if (t == 0)          begin chk("lit_frmst0", 32'(frmst), 32'd1); chk("lit_dout0", 32'(dataout), 32'h00); end
        if (t == 2)          chk("lit_stm", 32'(dataout), 32'h11);
        if (t == 19)         chk("lit_tug", 32'(dataout), 32'h44);
        if (t == 20)         chk("lit_spare", 32'(dataout), 32'h00);
        if (t == 811)        chk("lit_au4", 32'(dataout), 32'h22);
        if (t == 820)        chk("lit_vc4", 32'(dataout), 32'h33);
        if (t == FRM - 1)    begin
          chk("lit_row_end", 32'(row), 32'd8);
          chk("lit_col_end", 32'(col), 32'd89);
          chk("lit_sts_end", 32'(sts), 32'd2);
        end
        if (t == FRM)        begin chk("lit_frmst1", 32'(frmst), 32'd1); chk("lit_ainc_pre", 32'(ainc), 32'd0); end
        if (t == FRM + 1)    chk("lit_ainc_rise", 32'(ainc), 32'd1);
        if (t == FRM + 817)  chk("lit_h3_pos", 32'(dataout), 32'h22);
        if (t == FRM + 819)  chk("lit_stuff_en", 32'(vc4en), 32'd0);
        if (t == FRM + 820)  chk("lit_stuff", 32'(dataout), 32'h00);
        if (t == 2 * FRM)     chk("lit_ainc_last", 32'(ainc), 32'd1);
        if (t == 2 * FRM + 1) chk("lit_ainc_fall", 32'(ainc), 32'd0);
        if (t == 6 * FRM + 1) chk("lit_adec_rise", 32'(adec), 32'd1);
        if (t == 6 * FRM + 816) begin
          chk("lit_h3_au4en", 32'(au4en), 32'd0);
          chk("lit_h3_vc4en", 32'(vc4en), 32'd1);
        end
        if (t == 7 * FRM + 1) chk("lit_adec_fall", 32'(adec), 32'd0);
      end
    end
  end

  initial begin
    bit inc, dec;
    // run 0: directed requests in frames 0..6, random requests afterwards
    run = 0;
    do_reset();
    for (int i = 0; i < 13 * FRM; i++) begin
      inc = 1'b0;
      dec = 1'b0;
      if (t == 100) begin inc = 1'b1; dec = 1'b1; end
      if (t == 500) inc = 1'b1;
      if (t == 2 * FRM + 1000 || t == 3 * FRM + 1000 || t == 4 * FRM + 1000) inc = 1'b1;
      if (t == 5 * FRM + 50) dec = 1'b1;
      if (t >= 7 * FRM) begin
        inc = ($urandom_range(0, 1499) == 0);
        dec = ($urandom_range(0, 1499) == 0);
      end
      step(inc, dec, t < 4900);
    end

    // run 1: reset asserted in the H3 slot of a positive justification frame
    run = 1;
    do_reset();
    for (int i = 0; i < FRM + 816; i++) begin
      step(t == 10, 1'b0, 1'b0);
    end
    chk_en = 1'b0;
    chk("rst_ainc_before", 32'(ainc), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_dataout", 32'(dataout), 32'h00);
    chk("rst_ainc", 32'(ainc), 32'd0);
    chk("rst_adec", 32'(adec), 32'd0);
    chk("rst_row", 32'(row), 32'd0);
    chk("rst_col", 32'(col), 32'd0);

    // run 2: after release, no justification without a new request
    run = 2;
    do_reset();
    for (int i = 0; i < 2 * FRM; i++) begin
      step(1'b0, 1'b0, 1'b0);
    end
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
